// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access sequencer.
//   - state encoding of the sequencer FSM
//   - load/store size codes as presented on size_i
//   - default memory geometry
//   - helper returning the byte count of a size code
package dmem_pkg;

    localparam int unsigned DMEM_DEPTH  = 32;
    localparam int unsigned DMEM_ADDR_W = 5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Number of single-byte memory cycles for a size code; 0 flags the illegal code.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_B:    n = 3'd1;
            SZ_H:    n = 3'd2;
            SZ_W:    n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load result extension.
// Widens the assembled little-endian load bytes to 32 bits.
//   size_i     in   2  size code of the completed load
//   unsigned_i in   1  1 = zero-extend, 0 = sign-extend
//   capture_i  in  32  bytes gathered from memory, byte 0 in [7:0]
//   rdata_o    out 32  extended load result
module dmem_load_ext
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] capture_i,
    output logic [31:0] rdata_o
);

    logic fill_b;
    logic fill_h;

    assign fill_b = ~unsigned_i & capture_i[7];
    assign fill_h = ~unsigned_i & capture_i[15];

    always_comb begin
        rdata_o = capture_i;
        case (size_i)
            SZ_B:    rdata_o = {{24{fill_b}}, capture_i[7:0]};
            SZ_H:    rdata_o = {{16{fill_h}}, capture_i[15:0]};
            default: rdata_o = capture_i;
        endcase
    end

endmodule

// File: rtl/dmem_access_seq.sv
// Data-memory access sequencer.
// Breaks a byte/half/word load or store from the MEM stage into 1, 2 or 4 single-byte
// memory cycles (little-endian), stalls the pipeline while busy and returns an extended
// load result. Misaligned, out-of-range and illegal-size requests are rejected with err_o.
//   clk_i        in   1  clock
//   rst_i        in   1  synchronous active-high reset
//   req_i        in   1  access request, held until done_o/err_o
//   we_i         in   1  1 = store, 0 = load
//   size_i       in   2  0 byte, 1 half, 2 word, 3 illegal
//   unsigned_i   in   1  zero-extend loads when 1
//   addr_i       in  32  byte address
//   wdata_i      in  32  store data
//   stall_o      out  1  pipeline hold
//   done_o       out  1  completion pulse
//   err_o        out  1  error pulse
//   rdata_o      out 32  load result while done_o
//   mem_addr_o   out 32  memory byte address
//   mem_wdata_o  out 32  memory write byte in [7:0]
//   mem_we_o     out  1  memory write strobe
//   mem_re_o     out  1  memory read strobe
//   mem_rdata_i  in  32  memory read data, [7:0] used
module dmem_access_seq
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH  = DMEM_DEPTH,
    parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    output logic        mem_re_o,
    input  logic [31:0] mem_rdata_i
);

    state_e            state_q, state_d;
    logic [1:0]        count_q, count_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       capture_q, capture_d;

    logic [31:0]       req_n;
    logic              req_err;
    logic [1:0]        last_count;
    logic [4:0]        byte_lsb;
    logic [31:0]       ext_rdata;
    logic              unused_rdata;

    // Only the low byte of the memory read port carries data.
    assign unused_rdata = ^mem_rdata_i[31:8];

    // Request validation. The range test is written as addr > DEPTH - N so that
    // addresses near 2^32 cannot wrap around into range.
    always_comb begin
        req_n   = {29'd0, size_bytes(size_i)};
        req_err = 1'b0;
        if (size_i == 2'd3) begin
            req_err = 1'b1;
        end else if ((addr_i & (req_n - 32'd1)) != 32'd0) begin
            req_err = 1'b1;
        end else if (addr_i > (DEPTH - req_n)) begin
            req_err = 1'b1;
        end
    end

    always_comb begin
        case (size_q)
            SZ_B:    last_count = 2'd0;
            SZ_H:    last_count = 2'd1;
            default: last_count = 2'd3;
        endcase
    end

    assign byte_lsb = {count_q, 3'b000};

    dmem_load_ext u_load_ext (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .capture_i  (capture_q),
        .rdata_o    (ext_rdata)
    );

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        base_d      = base_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wdata_d     = wdata_q;
        capture_d   = capture_q;

        stall_o     = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        rdata_o     = 32'd0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        mem_we_o    = 1'b0;
        mem_re_o    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Combinational so the pipeline holds in the request cycle itself.
                stall_o = req_i;
                if (req_i) begin
                    if (req_err) begin
                        state_d = StErr;
                    end else begin
                        // In-range addresses fit in ADDR_W bits.
                        base_d    = addr_i[ADDR_W-1:0];
                        we_d      = we_i;
                        size_d    = size_i;
                        uns_d     = unsigned_i;
                        wdata_d   = wdata_i;
                        capture_d = 32'd0;
                        count_d   = 2'd0;
                        state_d   = StXfer;
                    end
                end
            end

            StXfer: begin
                stall_o     = 1'b1;
                mem_addr_o  = {{(32-ADDR_W){1'b0}}, base_q + ADDR_W'(count_q)};
                mem_we_o    = we_q;
                mem_re_o    = ~we_q;
                mem_wdata_o = {24'd0, wdata_q[byte_lsb +: 8]};
                if (!we_q) begin
                    capture_d[byte_lsb +: 8] = mem_rdata_i[7:0];
                end
                if (count_q == last_count) begin
                    count_d = 2'd0;
                    state_d = StDone;
                end else begin
                    count_d = count_q + 2'd1;
                end
            end

            StDone: begin
                done_o  = 1'b1;
                rdata_o = we_q ? 32'd0 : ext_rdata;
                state_d = StIdle;
            end

            StErr: begin
                err_o   = 1'b1;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            count_q   <= 2'd0;
            base_q    <= '0;
            we_q      <= 1'b0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            wdata_q   <= 32'd0;
            capture_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            base_q    <= base_d;
            we_q      <= we_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            wdata_q   <= wdata_d;
            capture_q <= capture_d;
        end
    end

endmodule

// File: doc/dmem_access_seq.md
Name: dmem_access_seq

Overview:
- Sequencer between the pipeline MEM stage and the byte-wide data memory (8-bit entries, 32 deep, combinational read, write on posedge).
- Turns one byte, halfword or word load/store request into 1, 2 or 4 single-byte memory cycles, little-endian.
- Stalls the pipeline while a request is in progress.
- Returns a zero- or sign-extended 32-bit load result, with alignment and range checking.

Parameters:
- DEPTH, 32, number of byte entries in the data memory.
- ADDR_W, 5, width of the memory byte address (DEPTH = 2**ADDR_W).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  1  access request; held until done_o or err_o
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- unsigned_i  in  1  load zero-extends when 1, sign-extends when 0
- addr_i  in  32  byte address
- wdata_i  in  32  store data; low bytes used
- stall_o  out  1  pipeline hold
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle error pulse
- rdata_o  out  32  load result, valid while done_o
- mem_addr_o  out  32  to memory addr_i
- mem_wdata_o  out  32  to memory wdata_i; byte in [7:0], upper bits 0
- mem_we_o  out  1  to memory MemWrite_i
- mem_re_o  out  1  to memory MemRead_i
- mem_rdata_i  in  32  from memory rdata_o; only [7:0] used

Behaviour:
- Clock is clk_i; reset is synchronous and active-high on rst_i. Both are fixed.
- Reset forces: state = IDLE, count = 0, all outputs 0, capture register 0.
- Byte count N = 1, 2 or 4 for size 0, 1 or 2.

State IDLE:
- On req_i, check for an error: size_i = 3, or addr_i not aligned to N, or addr_i + N > DEPTH.
- Error: err_o = 1 next cycle (state ERR), no memory access, then back to IDLE.
- Otherwise: latch addr, we, size, unsigned and wdata; clear capture; count = 0; go to XFER.
- stall_o = req_i, combinational, so the pipeline holds from the request cycle.

State XFER:
- mem_addr_o = base + count.
- mem_we_o = we; mem_re_o = !we.
- mem_wdata_o = {24'b0, wdata byte[count]}.
- On a load, capture byte[count] <= mem_rdata_i[7:0] at the posedge.
- count increments each cycle; after the cycle with count = N-1, go to DONE.
- stall_o = 1.

State DONE:
- done_o = 1; stall_o = 0; memory strobes 0.
- rdata_o = extended capture:
  - byte: bits [31:8] = signed ? capture bit 7 : 0
  - half: bits [31:16] = signed ? capture bit 15 : 0
  - word: the capture unchanged
- Stores present rdata_o = 0.
- Next state IDLE unconditionally.

State ERR:
- err_o = 1, stall_o = 0, then IDLE.

General rules:
- req_i is ignored outside IDLE. A req_i still high in the cycle after DONE/ERR starts a new access; the requester must drop req_i on done_o/err_o.
- Memory strobes are 0 in every state except XFER; mem_we_o and mem_re_o are never both 1.
- Latency from the request cycle t: done_o at t+1+N (byte t+2, half t+3, word t+5); err_o at t+1.
- Reset mid-XFER abandons the access. Bytes already written stay written; no done_o.
- Address arithmetic is 32-bit; the range check uses the unsigned compare addr_i > DEPTH - N, so there is no overflow.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding: IDLE = 0, XFER = 1, DONE = 2, ERR = 3
  - size codes: SZ_B = 0, SZ_H = 1, SZ_W = 2
  - DEPTH default
- Optional sub-module dmem_load_ext: combinational sign/zero extension (size, unsigned, capture -> rdata).
- The FSM, counter and checks stay in dmem_access_seq.

Test Plan:
- Word store: 0xDEADBEEF at addr 8, req at cycle t.
  - XFER writes mem[8..11] = EF, BE, AD, DE in cycles t+1..t+4.
  - done_o at t+5; stall_o high t..t+4.
- Word load from addr 8 after the store above -> rdata_o = 0xDEADBEEF with done_o at t+5.
- Byte load addr 11 (0xDE):
  - signed -> 0xFFFFFFDE
  - unsigned -> 0x000000DE
  - done_o at t+2
- Half load addr 10 (0xDEAD):
  - signed -> 0xFFFFDEAD
  - unsigned -> 0x0000DEAD
- Error cases, each giving err_o at t+1, no mem_we_o/mem_re_o ever, state back to IDLE:
  - word at addr 6 (misaligned)
  - half at addr 31 (misaligned and out of range)
  - word at addr 32
  - size_i = 3
- rst_i asserted at t+2 of a word store to addr 0:
  - only mem[0..1] written
  - no done_o
  - outputs 0 at t+3
  - a new req accepted at t+3.
